// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// the NOP word loaded on reset, register-field positions and the PC step.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;   // addi x0, x0, 0
    localparam int          RS1_LSB  = 15;
    localparam int          RS2_LSB  = 20;
    localparam int          RD_LSB   = 7;
    localparam int          REG_W    = 5;
    localparam int          PC_STEP  = 4;

    // Extract a 5-bit register index starting at bit position lsb.
    function automatic logic [REG_W-1:0] reg_field(input logic [31:0] word, input int lsb);
        return word[lsb +: REG_W];
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts request cycles that go unanswered by instruction memory.
// expire fires on the unanswered request cycle that brings the count to
// MAX_WAIT, so the owner can enter its fault state on that same edge.
module fetch_timeout_ctr #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam int              CW   = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]   LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] count_reg;

    assign expire = inc && (count_reg == LAST);

    // Wait counter: clear dominates, otherwise count unanswered requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the req/ack handshake with
// instruction memory, registers the returned word and exposes its rs1/rs2/rd
// fields to the register file. Handles downstream stall, redirect and a
// sticky fault for fetch timeout or misaligned redirect targets.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int          MAX_WAIT = 15
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    input  logic         stall,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc,
    output logic         inst_valid,
    output logic [31:0]  inst,
    output logic [N-1:0] inst_pc,
    output logic [4:0]   rs1,
    output logic [4:0]   rs2,
    output logic [4:0]   rd,
    output logic         fetch_fault
);

    fetch_state_t state_reg, state_next;
    logic [N-1:0] pc_reg, pc_next;
    logic [31:0]  inst_reg, inst_next;
    logic [N-1:0] inst_pc_reg, inst_pc_next;
    logic         valid_reg, valid_next;
    logic         fault_reg, fault_next;

    logic         accept;
    logic         ctr_clear;
    logic         ctr_inc;
    logic         expire;

    // A request is withheld while an unconsumed instruction is stalled.
    assign imem_req  = (state_reg == ST_REQ) && !(valid_reg && stall);
    assign imem_addr = pc_reg;
    assign accept    = imem_req && imem_ack;
    assign ctr_inc   = imem_req && !imem_ack;
    assign ctr_clear = redirect || accept || (state_next != ST_REQ);

    fetch_timeout_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (ctr_clear),
        .inc    (ctr_inc),
        .expire (expire)
    );

    // Next-state logic: redirect overrides everything, then per-state behaviour.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        inst_next    = inst_reg;
        inst_pc_next = inst_pc_reg;
        valid_next   = valid_reg;
        fault_next   = fault_reg;

        if (redirect) begin
            pc_next    = redirect_pc;
            valid_next = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                state_next = ST_FAULT;
                fault_next = 1'b1;
            end else begin
                state_next = ST_REQ;
                fault_next = 1'b0;
            end
        end else begin
            unique case (state_reg)
                ST_REQ: begin
                    if (accept) begin
                        // Any previously valid instruction is consumed this cycle.
                        inst_next    = imem_rdata;
                        inst_pc_next = pc_reg;
                        valid_next   = 1'b1;
                        pc_next      = pc_reg + N'(PC_STEP);
                    end else if (valid_reg && stall) begin
                        state_next = ST_HOLD;
                    end else begin
                        // Either nothing was valid or it was consumed.
                        valid_next = 1'b0;
                        if (expire) begin
                            state_next = ST_FAULT;
                            fault_next = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        valid_next = 1'b0;
                        state_next = ST_REQ;
                    end
                end
                ST_FAULT: begin
                    valid_next = 1'b0;
                end
                default: begin
                    state_next = ST_REQ;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_REQ;
            pc_reg      <= RESET_PC;
            inst_reg    <= NOP_INSN;
            inst_pc_reg <= '0;
            valid_reg   <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            inst_reg    <= inst_next;
            inst_pc_reg <= inst_pc_next;
            valid_reg   <= valid_next;
            fault_reg   <= fault_next;
        end
    end

    assign inst_valid  = valid_reg;
    assign inst        = inst_reg;
    assign inst_pc     = inst_pc_reg;
    assign fetch_fault = fault_reg;
    assign rs1         = reg_field(inst_reg, RS1_LSB);
    assign rs2         = reg_field(inst_reg, RS2_LSB);
    assign rd          = reg_field(inst_reg, RD_LSB);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized stimulus checked every cycle against a
// behavioural model plus an in-order scoreboard of fetched instructions.
module tb_fetch_unit;

    localparam int          N        = 32;
    localparam int          MAX_WAIT = 15;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk         = 1'b0;
    logic        rst         = 1'b0;
    logic        imem_ack    = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        stall       = 1'b0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        fetch_fault;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit #(
        .N        (N),
        .RESET_PC (RESET_PC),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Flags describe what the fetcher is doing: stopped by a fault, parked
    // holding a stalled instruction, or actively fetching.
    logic [31:0] m_pc      = RESET_PC;
    logic [31:0] m_inst    = 32'h0000_0013;
    logic [31:0] m_inst_pc = 32'h0;
    bit          m_valid   = 1'b0;
    bit          m_hold    = 1'b0;
    bit          m_fault   = 1'b0;
    int          m_wait    = 0;
    bit          m_req;
    logic [31:0] fetched_pc_q[$];
    logic [31:0] fetched_word_q[$];

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_pc = RESET_PC; m_inst = 32'h0000_0013; m_inst_pc = 32'h0;
            m_valid = 1'b0; m_hold = 1'b0; m_fault = 1'b0; m_wait = 0;
            fetched_pc_q.delete(); fetched_word_q.delete();
        end else begin
            m_req = !m_fault && !m_hold && !(m_valid && stall);
            if (redirect) begin
                m_pc = redirect_pc; m_valid = 1'b0; m_hold = 1'b0; m_wait = 0;
                m_fault = (redirect_pc[1:0] != 2'b00);
                fetched_pc_q.delete(); fetched_word_q.delete();
            end else if (m_fault) begin
                m_valid = 1'b0;
            end else if (m_hold) begin
                if (!stall) begin m_hold = 1'b0; m_valid = 1'b0; end
            end else if (m_req && imem_ack) begin
                m_inst = imem_rdata; m_inst_pc = m_pc; m_valid = 1'b1;
                m_pc = m_pc + 32'd4; m_wait = 0;
                fetched_pc_q.push_back(m_inst_pc);
                fetched_word_q.push_back(m_inst);
            end else if (m_valid && stall) begin
                m_hold = 1'b1; m_wait = 0;
            end else begin
                m_valid = 1'b0;
                m_wait++;
                if (m_wait == MAX_WAIT) begin m_fault = 1'b1; m_wait = 0; end
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    bit          exp_req;
    logic [31:0] exp_pc;
    logic [31:0] exp_word;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_req = !m_fault && !m_hold && !(m_valid && stall);
            check("imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) check("imem_addr", imem_addr, m_pc);
            check("inst_valid", 32'(inst_valid), 32'(m_valid));
            check("inst", inst, m_inst);
            check("inst_pc", inst_pc, m_inst_pc);
            check("rs1", 32'(rs1), 32'(m_inst[19:15]));
            check("rs2", 32'(rs2), 32'(m_inst[24:20]));
            check("rd", 32'(rd), 32'(m_inst[11:7]));
            check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
            if (inst_valid && !stall) begin
                if (fetched_pc_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL consume_order: got pc %h consumed, expected no instruction pending", inst_pc);
                end else begin
                    exp_pc   = fetched_pc_q.pop_front();
                    exp_word = fetched_word_q.pop_front();
                    $display("consume pc=%h inst=%h", inst_pc, inst);
                    check("consume_pc", inst_pc, exp_pc);
                    check("consume_word", inst, exp_word);
                end
            end
        end
    end

    // ---------------- directed and random stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values while reset is asserted.
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(imem_req), 32'd1);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_rs1", 32'(rs1), 32'd0);
        check("rst_fault", 32'(fetch_fault), 32'd0);

        // 1: back-to-back acks.
        rst = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        #1;
        check("t1_req", 32'(imem_req), 32'd1);
        check("t1_addr0", imem_addr, 32'h0);
        tick();
        $display("t1 ack1 addr=%h inst=%h", imem_addr, inst);
        check("t1_addr4", imem_addr, 32'h4);
        check("t1_valid", 32'(inst_valid), 32'd1);
        check("t1_inst0", inst, 32'h0050_0093);
        check("t1_rd1", 32'(rd), 32'd1);
        check("t1_rs2", 32'(rs2), 32'd5);
        imem_rdata = 32'h00A0_0113;
        tick();
        $display("t1 ack2 addr=%h inst=%h", imem_addr, inst);
        check("t1_addr8", imem_addr, 32'h8);
        check("t1_inst1", inst, 32'h00A0_0113);
        check("t1_inst_pc", inst_pc, 32'h4);
        check("t1_rd2", 32'(rd), 32'd2);
        check("t1_rs1", 32'(rs1), 32'd0);

        // 2: stall for three cycles; acks during hold must be ignored.
        imem_ack = 1'b0; stall = 1'b1;
        #1;
        check("t2_req_off", 32'(imem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
            tick();
            $display("t2 stall cycle %0d inst=%h", i, inst);
            check("t2_req_hold", 32'(imem_req), 32'd0);
            check("t2_frozen", inst, 32'h00A0_0113);
            check("t2_frozen_pc", inst_pc, 32'h4);
        end
        imem_ack = 1'b0; stall = 1'b0;
        tick();
        $display("t2 resume addr=%h", imem_addr);
        check("t2_resume_req", 32'(imem_req), 32'd1);
        check("t2_resume_addr", imem_addr, 32'h8);
        check("t2_resume_valid", 32'(inst_valid), 32'd0);

        // 3: redirect in the same cycle as an ack.
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        $display("t3 redirect addr=%h", imem_addr);
        redirect = 1'b0; imem_ack = 1'b0;
        check("t3_addr", imem_addr, 32'h100);
        check("t3_valid", 32'(inst_valid), 32'd0);

        // 4: timeout after MAX_WAIT unanswered request cycles.
        for (int i = 0; i < MAX_WAIT - 1; i++) begin
            tick();
            check("t4_no_fault_yet", 32'(fetch_fault), 32'd0);
        end
        tick();
        $display("t4 timeout fault=%0d", fetch_fault);
        check("t4_fault", 32'(fetch_fault), 32'd1);
        check("t4_req_off", 32'(imem_req), 32'd0);
        tick();
        check("t4_sticky", 32'(fetch_fault), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        $display("t4 recover addr=%h", imem_addr);
        check("t4_clear", 32'(fetch_fault), 32'd0);
        check("t4_addr", imem_addr, 32'h40);
        check("t4_req_on", 32'(imem_req), 32'd1);

        // 5: misaligned redirect, then PC wrap.
        redirect = 1'b1; redirect_pc = 32'h102;
        tick();
        $display("t5 misaligned fault=%0d", fetch_fault);
        check("t5_fault", 32'(fetch_fault), 32'd1);
        check("t5_req_off", 32'(imem_req), 32'd0);
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
        check("t5_fault_clr", 32'(fetch_fault), 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h00A0_0113;
        tick();
        imem_ack = 1'b0;
        $display("t5 wrap addr=%h inst_pc=%h", imem_addr, inst_pc);
        check("t5_wrap_addr", imem_addr, 32'h0);
        check("t5_wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        check("t5_wrap_nofault", 32'(fetch_fault), 32'd0);

        // Random phase, checked every cycle by the model.
        for (int i = 0; i < 600; i++) begin
            imem_ack   = ($urandom_range(0, 99) < 70);
            imem_rdata = $urandom;
            stall      = ($urandom_range(0, 99) < 30);
            redirect   = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 7) == 0)
                redirect_pc = 32'hFFFF_FFF0 | {30'h0, 2'($urandom_range(0, 1) * 2)};
            else
                redirect_pc = ($urandom & 32'h0000_0FFC) | {30'h0, 2'($urandom_range(0, 5) == 0 ? 2 : 0)};
            tick();
        end
        imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;

        // 6: asynchronous reset while holding with an ack pending.
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        tick();
        stall = 1'b1;
        tick();
        check("t6_hold_req", 32'(imem_req), 32'd0);
        check("t6_hold_valid", 32'(inst_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        $display("t6 async reset addr=%h valid=%0d", imem_addr, inst_valid);
        check("t6_addr", imem_addr, RESET_PC);
        check("t6_req", 32'(imem_req), 32'd1);
        check("t6_valid", 32'(inst_valid), 32'd0);
        check("t6_inst", inst, 32'h0000_0013);
        check("t6_inst_pc", inst_pc, 32'h0);
        check("t6_rd", 32'(rd), 32'd0);
        check("t6_fault", 32'(fetch_fault), 32'd0);
        imem_ack = 1'b0; stall = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("t6_release_addr", imem_addr, RESET_PC);
        check("t6_release_req", 32'(imem_req), 32'd1);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
